fetch_sequencer: RTL and testbench

//  Control FSM for the instruction-fetch unit of the 5-stage pipeline. Drives the fetch unit's
//  PC-enable and next-PC select, plus the branch target. Sequences boot, load-use stalls, taken-branch

---
 rtl/fetch_seq_pkg.sv | 16 +
 rtl/fetch_sequencer_load_use_detect.sv | 12 +
 rtl/fetch_sequencer.sv | 114 +++++++++++
 tb/tb_fetch_sequencer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg: state encoding and constants shared by the fetch sequencer.
package fetch_seq_pkg;
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        HALT  = 2'd3
    } state_t;
    localparam logic [4:0] REG_X0 = 5'd0;
    localparam int LU_STALL_MIN = 1;
    localparam int LU_STALL_MAX = 3;
    // Out-of-range bubble counts are pinned to the nearest legal value.
    function automatic int lu_stall_clamp(input int n);
        return (n < LU_STALL_MIN) ? LU_STALL_MIN : (n > LU_STALL_MAX) ? LU_STALL_MAX : n;
    endfunction
endpackage

// File: rtl/fetch_sequencer_load_use_detect.sv
// load_use_detect: flags a load in EX whose destination feeds the instruction in ID.
module load_use_detect
    import fetch_seq_pkg::*;
(
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_ex_memread,
    input  logic [4:0] i_ex_rd,
    output logic       o_hazard
);
    assign o_hazard = i_ex_memread && (i_ex_rd != REG_X0) && ((i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2));
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch-unit control FSM sequencing boot, load-use stalls, redirects and halt.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int Width    = 32,
    parameter int LU_STALL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             branch_taken,
    input  logic [Width-1:0] branch_target,
    input  logic             halt_req,
    output logic             PCen,
    output logic             Asel,
    output logic [Width-1:0] branchaddress,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halted,
    output logic [Width-1:0] stall_cnt,
    output logic [Width-1:0] flush_cnt
);
    localparam int         LU     = lu_stall_clamp(LU_STALL);
    localparam logic [1:0] LU_REM = 2'(LU - 1);
    localparam logic [Width-1:0] ONE = {{(Width-1){1'b0}}, 1'b1};

    state_t           r_state, w_next;
    logic [1:0]       r_rem, w_rem_next;
    logic [Width-1:0] r_stall_cnt, r_flush_cnt;
    logic             w_hazard, w_stall_inc, w_flush_inc;

    load_use_detect u_lud (
        .i_id_rs1    (id_rs1),
        .i_id_rs2    (id_rs2),
        .i_ex_memread(ex_memread),
        .i_ex_rd     (ex_rd),
        .o_hazard    (w_hazard)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= BOOT;
            r_rem       <= 2'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_next;
            r_rem   <= w_rem_next;
            if (w_stall_inc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + ONE;
            if (w_flush_inc && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + ONE;
        end
    end

    always_comb begin
        PCen          = 1'b1;
        Asel          = 1'b0;
        branchaddress = branch_target;
        ifid_en       = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        halted        = 1'b0;
        w_next        = r_state;
        w_rem_next    = r_rem;
        w_stall_inc   = 1'b0;
        w_flush_inc   = 1'b0;
        if (rst || (r_state == BOOT)) begin
            PCen       = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            w_next     = RUN;
        end else if (r_state == HALT) begin
            PCen       = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            halted     = 1'b1;
        end else if (branch_taken) begin
            // A redirect outranks everything and also cancels any stall in progress.
            Asel        = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            w_flush_inc = 1'b1;
            w_next      = RUN;
            w_rem_next  = 2'd0;
        end else if (r_state == STALL) begin
            PCen        = 1'b0;
            ifid_en     = 1'b0;
            idex_flush  = 1'b1;
            w_stall_inc = 1'b1;
            w_rem_next  = r_rem - 2'd1;
            w_next      = (r_rem == 2'd1) ? RUN : STALL;
        end else if (halt_req) begin
            PCen       = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
            w_next     = HALT;
        end else if (w_hazard) begin
            PCen        = 1'b0;
            ifid_en     = 1'b0;
            idex_flush  = 1'b1;
            w_stall_inc = 1'b1;
            w_next      = (LU > 1) ? STALL : RUN;
            w_rem_next  = (LU > 1) ? LU_REM : 2'd0;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed stimulus with a queue scoreboard over three sequencer configurations.
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        rst, mr, bt, hr;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] tgt;

    logic        a_pc, a_as, a_ie, a_if, a_xf, a_h;
    logic [31:0] a_ba, a_sc, a_fc;
    logic        b_pc, b_as, b_ie, b_if, b_xf, b_h;
    logic [31:0] b_ba, b_sc, b_fc;
    logic        s_pc, s_as, s_ie, s_if, s_xf, s_h;
    logic [1:0]  s_ba, s_sc, s_fc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       nm;
        int          d;
        logic [5:0]  ctl;
        logic [31:0] ba;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;
    exp_t q[$];

    localparam logic [5:0] C_RST  = 6'b000110;
    localparam logic [5:0] C_RUN  = 6'b101000;
    localparam logic [5:0] C_STL  = 6'b000010;
    localparam logic [5:0] C_BR   = 6'b111110;
    localparam logic [5:0] C_HREQ = 6'b000100;
    localparam logic [5:0] C_HALT = 6'b000111;

    always #5 clk = ~clk;

    fetch_sequencer #(.Width(32), .LU_STALL(1)) dut1 (
        .clk(clk), .rst(rst), .id_rs1(rs1), .id_rs2(rs2), .ex_memread(mr), .ex_rd(rd),
        .branch_taken(bt), .branch_target(tgt), .halt_req(hr),
        .PCen(a_pc), .Asel(a_as), .branchaddress(a_ba), .ifid_en(a_ie), .ifid_flush(a_if),
        .idex_flush(a_xf), .halted(a_h), .stall_cnt(a_sc), .flush_cnt(a_fc)
    );
    fetch_sequencer #(.Width(32), .LU_STALL(3)) dut3 (
        .clk(clk), .rst(rst), .id_rs1(rs1), .id_rs2(rs2), .ex_memread(mr), .ex_rd(rd),
        .branch_taken(bt), .branch_target(tgt), .halt_req(hr),
        .PCen(b_pc), .Asel(b_as), .branchaddress(b_ba), .ifid_en(b_ie), .ifid_flush(b_if),
        .idex_flush(b_xf), .halted(b_h), .stall_cnt(b_sc), .flush_cnt(b_fc)
    );
    fetch_sequencer #(.Width(2), .LU_STALL(1)) dut_sat (
        .clk(clk), .rst(rst), .id_rs1(rs1), .id_rs2(rs2), .ex_memread(mr), .ex_rd(rd),
        .branch_taken(bt), .branch_target(tgt[1:0]), .halt_req(hr),
        .PCen(s_pc), .Asel(s_as), .branchaddress(s_ba), .ifid_en(s_ie), .ifid_flush(s_if),
        .idex_flush(s_xf), .halted(s_h), .stall_cnt(s_sc), .flush_cnt(s_fc)
    );

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [5:0]  c;
            logic [31:0] ba, sc, fc;
            e = q.pop_front();
            if (e.d == 1) begin
                c = {a_pc, a_as, a_ie, a_if, a_xf, a_h}; ba = a_ba; sc = a_sc; fc = a_fc;
            end else if (e.d == 3) begin
                c = {b_pc, b_as, b_ie, b_if, b_xf, b_h}; ba = b_ba; sc = b_sc; fc = b_fc;
            end else begin
                c = {s_pc, s_as, s_ie, s_if, s_xf, s_h}; ba = {30'd0, s_ba}; sc = {30'd0, s_sc}; fc = {30'd0, s_fc};
            end
            checks++;
            if ({c, ba, sc, fc} !== {e.ctl, e.ba, e.sc, e.fc}) begin
                errors++;
                $display("FAIL %s dut%0d got ctl=%b ba=%h sc=%h fc=%h exp ctl=%b ba=%h sc=%h fc=%h",
                         e.nm, e.d, c, ba, sc, fc, e.ctl, e.ba, e.sc, e.fc);
            end
        end
    end

    task automatic drv(input logic r, input logic m, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic b, input logic h, input logic [31:0] t);
        rst = r; mr = m; rd = d; rs1 = s1; rs2 = s2; bt = b; hr = h; tgt = t;
    endtask

    task automatic chk(input string nm, input int d, input logic [5:0] c, input logic [31:0] s, input logic [31:0] f);
        exp_t e;
        e.nm = nm; e.d = d; e.ctl = c; e.sc = s; e.fc = f;
        e.ba = (d == 0) ? {30'd0, tgt[1:0]} : tgt;
        q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drv(1, 0, 0, 0, 0, 0, 0, 32'h0); tick;
        chk("rst2", 1, C_RST, 0, 0); chk("rst2", 3, C_RST, 0, 0); tick;
        chk("rst3", 1, C_RST, 0, 0); chk("rst3", 0, C_RST, 0, 0); tick;
        drv(0, 0, 0, 0, 0, 0, 0, 32'h0);
        chk("boot", 1, C_RST, 0, 0); chk("boot", 3, C_RST, 0, 0); tick;
        chk("run", 1, C_RUN, 0, 0); chk("run", 0, C_RUN, 0, 0); tick;
        drv(0, 1, 5, 0, 5, 0, 0, 32'h0);
        chk("lu", 1, C_STL, 0, 0); chk("lu", 3, C_STL, 0, 0); chk("lu", 0, C_STL, 0, 0); tick;
        drv(0, 0, 0, 0, 0, 0, 0, 32'h0);
        chk("lu_after", 1, C_RUN, 1, 0); chk("lu3_b2", 3, C_STL, 1, 0); chk("lu_after", 0, C_RUN, 1, 0); tick;
        chk("lu_idle", 1, C_RUN, 1, 0); chk("lu3_b3", 3, C_STL, 2, 0); tick;
        chk("lu_idle", 1, C_RUN, 1, 0); chk("lu3_run", 3, C_RUN, 3, 0); tick;
        drv(0, 1, 0, 0, 0, 0, 0, 32'h0);
        chk("rd0", 1, C_RUN, 1, 0); chk("rd0", 3, C_RUN, 3, 0); tick;
        drv(0, 0, 5, 5, 0, 0, 0, 32'h0);
        chk("noload", 1, C_RUN, 1, 0); tick;
        drv(0, 0, 0, 0, 0, 1, 0, 32'h0000_0040);
        chk("br", 1, C_BR, 1, 0); chk("br", 3, C_BR, 3, 0); tick;
        drv(0, 0, 0, 0, 0, 0, 0, 32'h0000_0040);
        chk("br_after", 1, C_RUN, 1, 1); chk("br_after", 3, C_RUN, 3, 1); chk("br_after", 0, C_RUN, 1, 1); tick;
        drv(0, 1, 5, 0, 5, 1, 1, 32'h0000_0080);
        chk("simul", 1, C_BR, 1, 1); chk("simul", 3, C_BR, 3, 1); tick;
        drv(0, 0, 0, 0, 0, 0, 0, 32'h0000_0080);
        chk("simul_after", 1, C_RUN, 1, 2); chk("simul_after", 3, C_RUN, 3, 2); tick;
        drv(0, 1, 7, 7, 0, 0, 0, 32'h0);
        chk("ab_haz", 1, C_STL, 1, 2); chk("ab_haz", 3, C_STL, 3, 2); tick;
        drv(0, 0, 0, 0, 0, 1, 0, 32'h0000_0100);
        chk("ab_br", 3, C_BR, 4, 2); chk("ab_br", 1, C_BR, 2, 2); tick;
        drv(0, 0, 0, 0, 0, 0, 0, 32'h0000_0100);
        chk("ab_run", 3, C_RUN, 4, 3); chk("ab_run", 1, C_RUN, 2, 3); tick;
        chk("ab_run2", 3, C_RUN, 4, 3); tick;
        drv(0, 1, 9, 9, 9, 0, 0, 32'h0);
        chk("sat1", 0, C_STL, 2, 3); chk("sat1", 1, C_STL, 2, 3); tick;
        chk("sat2", 0, C_STL, 3, 3); chk("sat2", 1, C_STL, 3, 3); tick;
        chk("sat3", 0, C_STL, 3, 3); chk("sat3", 1, C_STL, 4, 3); tick;
        drv(0, 0, 0, 0, 0, 0, 0, 32'h0);
        chk("sat_hold", 0, C_RUN, 3, 3); chk("sat_cnt", 1, C_RUN, 5, 3); tick;
        drv(0, 0, 0, 0, 0, 1, 0, 32'h0000_0043);
        chk("fsat_br", 0, C_BR, 3, 3); chk("fsat_br", 1, C_BR, 5, 3); tick;
        drv(0, 0, 0, 0, 0, 0, 0, 32'h0000_0043);
        chk("fsat_hold", 0, C_RUN, 3, 3); chk("fsat_cnt", 1, C_RUN, 5, 4); tick;
        drv(0, 0, 0, 0, 0, 0, 1, 32'h0);
        chk("halt_req", 1, C_HREQ, 5, 4); tick;
        drv(0, 0, 0, 0, 0, 1, 0, 32'h0000_0200);
        chk("halt_br", 1, C_HALT, 5, 4); tick;
        drv(0, 1, 5, 5, 0, 0, 0, 32'h0);
        chk("halt_haz", 1, C_HALT, 5, 4); tick;
        drv(1, 0, 0, 0, 0, 0, 0, 32'h0);
        chk("halt_rst", 1, C_RST, 5, 4); tick;
        chk("halt_rst2", 1, C_RST, 0, 0); tick;
        drv(0, 0, 0, 0, 0, 0, 0, 32'h0);
        chk("reboot", 1, C_RST, 0, 0); tick;
        chk("rerun", 1, C_RUN, 0, 0); tick;
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending entries exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
